vdp_port: RTL and testbench

- CPU-side register/port front end of the TMS9918-style VDP; sits directly upstream of the video block.
- Decodes CPU writes and reads on the data port (0x98) and control port (0x99).
- Holds VDP registers R0–R7 and the VRAM address pointer, and drives the VRAM port-A strobes.
- Derives every table base, mode and colour input of the video stage, and assembles the status byte from the video stage's flags.

---
 rtl/vdp_port.sv | 230 +++++++++++++++++++++++
 tb/tb_vdp_port.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdp_port.sv
// CPU port front end of the TMS9918-style VDP: registers R0-R7, VRAM pointer, prefetch and status byte.
// VRAM access one cycle after the strobe, reads take 1+RD_LAT cycles; strobes arriving while busy are dropped.
module vdp_port #(
    parameter int ADDR_W = 14,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              port_sel,
    input  logic              cpu_wr,
    input  logic              cpu_rd,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              busy,
    output logic [ADDR_W-1:0] vga_addr,
    output logic              vga_wr,
    output logic              vga_rd,
    output logic [7:0]        vga_din,
    input  logic [7:0]        vga_dout,
    output logic [1:0]        mode,
    output logic [13:0]       name_table_addr,
    output logic [13:0]       color_table_addr,
    output logic [13:0]       font_addr,
    output logic [13:0]       sprite_attr_addr,
    output logic [13:0]       sprite_pattern_table_addr,
    output logic              video_on,
    output logic              vert_retrace_int,
    output logic              sprite_large,
    output logic              sprite_enlarged,
    output logic [3:0]        text_color,
    output logic [3:0]        back_color,
    input  logic              interrupt_flag,
    input  logic              sprite_collision,
    input  logic              too_many_sprites,
    input  logic [4:0]        sprite5,
    output logic              vdp_int_n
);

    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [LAT_W-1:0]   wait_cnt;
    logic [7:0]         regs [8];
    logic [ADDR_W-1:0]  pointer;
    logic [7:0]         rbuf;
    logic [7:0]         latch;
    logic               latch_full;
    logic [7:0]         wdata;
    logic               f_flag;
    logic               c_flag;
    logic               irq_q;

    logic               accept;
    logic               wr_go;
    logic               rd_go;
    logic               data_wr;
    logic               ctrl_wr;
    logic               data_rd;
    logic               stat_rd;
    logic               read_setup;
    logic               wait_last;
    logic [13:0]        ptr_load;

    // Strobes are only taken in IDLE; a simultaneous read is discarded in favour of the write.
    assign accept     = (state == S_IDLE);
    assign wr_go      = cpu_wr && accept;
    assign rd_go      = cpu_rd && !cpu_wr && accept;
    assign data_wr    = wr_go && !port_sel;
    assign ctrl_wr    = wr_go && port_sel;
    assign data_rd    = rd_go && !port_sel;
    assign stat_rd    = rd_go && port_sel;
    assign read_setup = ctrl_wr && latch_full && (cpu_din[7:6] == 2'b00);
    assign wait_last  = (state == S_WAIT) && (wait_cnt == LAT_W'(RD_LAT - 1));
    assign ptr_load   = {cpu_din[5:0], latch};

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_ISSUE) begin
                wait_cnt <= '0;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + LAT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        vga_wr    = 1'b0;
        vga_rd    = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (data_wr) begin
                    state_nxt = S_WRITE;
                end else if (data_rd || read_setup) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_WRITE: begin
                vga_wr    = 1'b1;
                state_nxt = S_IDLE;
            end
            S_ISSUE: begin
                vga_rd    = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (wait_last) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign vga_addr = pointer;
    assign vga_din  = wdata;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= 8'h00;
            end
            pointer    <= '0;
            rbuf       <= 8'h00;
            latch      <= 8'h00;
            latch_full <= 1'b0;
            wdata      <= 8'h00;
            cpu_dout   <= 8'h00;
            f_flag     <= 1'b0;
            c_flag     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            irq_q <= interrupt_flag;

            // Setting beats a same-cycle status-read clear so no event is lost.
            if (interrupt_flag && !irq_q) begin
                f_flag <= 1'b1;
            end else if (stat_rd) begin
                f_flag <= 1'b0;
            end
            if (sprite_collision) begin
                c_flag <= 1'b1;
            end else if (stat_rd) begin
                c_flag <= 1'b0;
            end

            if (ctrl_wr) begin
                if (!latch_full) begin
                    latch      <= cpu_din;
                    latch_full <= 1'b1;
                end else begin
                    latch_full <= 1'b0;
                    if (cpu_din[7]) begin
                        regs[cpu_din[2:0]] <= latch;
                    end else begin
                        pointer <= ADDR_W'(ptr_load);
                    end
                end
            end
            if (data_wr || data_rd || stat_rd) begin
                latch_full <= 1'b0;
            end

            if (data_wr) begin
                wdata <= cpu_din;
            end
            if (data_rd) begin
                cpu_dout <= rbuf;
            end
            if (stat_rd) begin
                cpu_dout <= {f_flag, too_many_sprites, c_flag, sprite5};
            end

            // Pointer only moves outside IDLE, so it never collides with a control-port load.
            if (state == S_WRITE) begin
                rbuf    <= wdata;
                pointer <= pointer + ADDR_W'(1);
            end
            if (wait_last) begin
                rbuf    <= vga_dout;
                pointer <= pointer + ADDR_W'(1);
            end
        end
    end

    // M1 (text) outranks M2 (multicolour), which outranks M3 (graphics II).
    always_comb begin
        mode = 2'd1;
        if (regs[1][4]) begin
            mode = 2'd0;
        end else if (regs[1][3]) begin
            mode = 2'd3;
        end else if (regs[0][1]) begin
            mode = 2'd2;
        end
    end

    assign name_table_addr           = {regs[2][3:0], 10'b0};
    assign sprite_attr_addr          = {regs[5][6:0], 7'b0};
    assign sprite_pattern_table_addr = {regs[6][2:0], 11'b0};
    assign color_table_addr          = (mode == 2'd2) ? {regs[3][7], 13'b0} : {regs[3], 6'b0};
    assign font_addr                 = (mode == 2'd2) ? {regs[4][2], 13'b0} : {regs[4][2:0], 11'b0};

    assign video_on         = regs[1][6];
    assign vert_retrace_int = regs[1][5];
    assign sprite_large     = regs[1][1];
    assign sprite_enlarged  = regs[1][0];
    assign text_color       = regs[7][7:4];
    assign back_color       = regs[7][3:0];
    assign vdp_int_n        = !(f_flag && regs[1][5]);

    logic unused_reg_bits;
    assign unused_reg_bits = ^{regs[0][7:2], regs[0][0], regs[1][7], regs[1][2],
                               regs[2][7:4], regs[4][7:3], regs[5][7], regs[6][7:3]};

endmodule

// File: tb/tb_vdp_port.sv
// Directed bench for vdp_port with a behavioural VRAM (1-cycle read latency) on port A.
module tb_vdp_port;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        port_sel = 1'b0;
    logic        cpu_wr = 1'b0;
    logic        cpu_rd = 1'b0;
    logic [7:0]  cpu_din = 8'h00;
    logic [7:0]  cpu_dout;
    logic        busy;
    logic [13:0] vga_addr;
    logic        vga_wr;
    logic        vga_rd;
    logic [7:0]  vga_din;
    logic [7:0]  vga_dout;
    logic [1:0]  mode;
    logic [13:0] name_table_addr, color_table_addr, font_addr;
    logic [13:0] sprite_attr_addr, sprite_pattern_table_addr;
    logic        video_on, vert_retrace_int, sprite_large, sprite_enlarged;
    logic [3:0]  text_color, back_color;
    logic        interrupt_flag = 1'b0;
    logic        sprite_collision = 1'b0;
    logic        too_many_sprites = 1'b0;
    logic [4:0]  sprite5 = 5'h00;
    logic        vdp_int_n;

    int total = 0;
    int bad = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    logic [13:0] last_wr_addr = '0;
    logic [7:0]  last_wr_dat = '0;
    logic [7:0]  vram [16384];

    always #5 clk = ~clk;

    vdp_port #(.ADDR_W(14), .RD_LAT(1)) dut (
        .clk(clk), .n_reset(n_reset), .port_sel(port_sel), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
        .cpu_din(cpu_din), .cpu_dout(cpu_dout), .busy(busy), .vga_addr(vga_addr),
        .vga_wr(vga_wr), .vga_rd(vga_rd), .vga_din(vga_din), .vga_dout(vga_dout),
        .mode(mode), .name_table_addr(name_table_addr), .color_table_addr(color_table_addr),
        .font_addr(font_addr), .sprite_attr_addr(sprite_attr_addr),
        .sprite_pattern_table_addr(sprite_pattern_table_addr), .video_on(video_on),
        .vert_retrace_int(vert_retrace_int), .sprite_large(sprite_large),
        .sprite_enlarged(sprite_enlarged), .text_color(text_color), .back_color(back_color),
        .interrupt_flag(interrupt_flag), .sprite_collision(sprite_collision),
        .too_many_sprites(too_many_sprites), .sprite5(sprite5), .vdp_int_n(vdp_int_n)
    );

    always @(posedge clk) begin
        if (vga_wr) begin
            vram[vga_addr] <= vga_din;
            wr_cnt         <= wr_cnt + 1;
            last_wr_addr   <= vga_addr;
            last_wr_dat    <= vga_din;
        end
        if (vga_rd) begin
            vga_dout <= vram[vga_addr];
            rd_cnt   <= rd_cnt + 1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle;
        int n = 0;
        while (busy !== 1'b0 && n < 20) begin
            tick;
            n++;
        end
        check("busy_timeout", {31'b0, busy}, 32'd0);
    endtask

    task automatic cpu_write(input logic sel, input logic [7:0] d);
        port_sel = sel;
        cpu_din  = d;
        cpu_wr   = 1'b1;
        tick;
        cpu_wr   = 1'b0;
    endtask

    task automatic cpu_read(input logic sel);
        port_sel = sel;
        cpu_rd   = 1'b1;
        tick;
        cpu_rd   = 1'b0;
    endtask

    task automatic set_reg(input logic [2:0] r, input logic [7:0] v);
        cpu_write(1'b1, v);
        cpu_write(1'b1, {5'b10000, r});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int snap;
        repeat (3) tick;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_vga_wr", {31'b0, vga_wr}, 32'd0);
        check("rst_vga_rd", {31'b0, vga_rd}, 32'd0);
        check("rst_cpu_dout", {24'b0, cpu_dout}, 32'h00);
        check("rst_int_n", {31'b0, vdp_int_n}, 32'd1);
        check("rst_mode", {30'b0, mode}, 32'd1);
        check("rst_vga_addr", {18'b0, vga_addr}, 32'h0000);
        n_reset = 1'b1;
        tick;

        // Register writes through the two-byte control sequence.
        set_reg(3'd1, 8'h00);
        check("r1_zero_video_on", {31'b0, video_on}, 32'd0);
        set_reg(3'd1, 8'h60);
        check("video_on", {31'b0, video_on}, 32'd1);
        check("vert_retrace_int", {31'b0, vert_retrace_int}, 32'd1);
        check("mode_gfx1", {30'b0, mode}, 32'd1);

        // Write setup at 0x3FFF, then pointer wrap.
        cpu_write(1'b1, 8'hFF);
        cpu_write(1'b1, 8'h7F);
        cpu_write(1'b0, 8'hA5);
        check("wr_pulse", {31'b0, vga_wr}, 32'd1);
        check("wr_addr_top", {18'b0, vga_addr}, 32'h3FFF);
        check("wr_din", {24'b0, vga_din}, 32'hA5);
        check("wr_busy", {31'b0, busy}, 32'd1);
        tick;
        check("wr_single_cycle", {31'b0, vga_wr}, 32'd0);
        cpu_write(1'b0, 8'h5A);
        check("wr_addr_wrap", {18'b0, vga_addr}, 32'h0000);
        wait_idle;

        // Preload 0x0100/0x0101 through the data port.
        cpu_write(1'b1, 8'h00);
        cpu_write(1'b1, 8'h41);
        cpu_write(1'b0, 8'h11);
        wait_idle;
        cpu_write(1'b0, 8'h22);
        wait_idle;

        // Read setup and prefetching data reads.
        snap = rd_cnt;
        cpu_write(1'b1, 8'h00);
        cpu_write(1'b1, 8'h01);
        check("setup_rd_pulse", {31'b0, vga_rd}, 32'd1);
        check("setup_rd_addr", {18'b0, vga_addr}, 32'h0100);
        wait_idle;
        check("setup_rd_count", rd_cnt, snap + 1);
        cpu_read(1'b0);
        check("read1_data", {24'b0, cpu_dout}, 32'h11);
        check("read1_prefetch_addr", {18'b0, vga_addr}, 32'h0101);
        check("read1_prefetch_rd", {31'b0, vga_rd}, 32'd1);
        wait_idle;
        cpu_read(1'b0);
        check("read2_data", {24'b0, cpu_dout}, 32'h22);
        check("read2_prefetch_addr", {18'b0, vga_addr}, 32'h0102);
        wait_idle;

        // Mode priority and table bases.
        set_reg(3'd1, 8'h10);
        set_reg(3'd0, 8'h02);
        check("mode_text", {30'b0, mode}, 32'd0);
        set_reg(3'd1, 8'h08);
        check("mode_multi", {30'b0, mode}, 32'd3);
        set_reg(3'd1, 8'h00);
        check("mode_gfx2", {30'b0, mode}, 32'd2);
        set_reg(3'd4, 8'h07);
        set_reg(3'd3, 8'hFF);
        check("font_gfx2", {18'b0, font_addr}, 32'h2000);
        check("color_gfx2", {18'b0, color_table_addr}, 32'h2000);
        set_reg(3'd0, 8'h00);
        check("font_gfx1", {18'b0, font_addr}, 32'h3800);
        check("color_gfx1", {18'b0, color_table_addr}, 32'h3FC0);
        set_reg(3'd2, 8'h0F);
        set_reg(3'd5, 8'h7F);
        set_reg(3'd6, 8'h07);
        set_reg(3'd7, 8'hF4);
        check("name_base", {18'b0, name_table_addr}, 32'h3C00);
        check("sprite_attr_base", {18'b0, sprite_attr_addr}, 32'h3F80);
        check("sprite_pat_base", {18'b0, sprite_pattern_table_addr}, 32'h3800);
        check("text_color", {28'b0, text_color}, 32'hF);
        check("back_color", {28'b0, back_color}, 32'h4);
        set_reg(3'd1, 8'h03);
        check("sprite_large", {31'b0, sprite_large}, 32'd1);
        check("sprite_enlarged", {31'b0, sprite_enlarged}, 32'd1);

        // Interrupt flag, collision flag and status read.
        set_reg(3'd1, 8'h20);
        check("int_n_idle", {31'b0, vdp_int_n}, 32'd1);
        too_many_sprites = 1'b1;
        sprite5 = 5'h15;
        interrupt_flag = 1'b1;
        tick;
        interrupt_flag = 1'b0;
        check("int_n_asserted", {31'b0, vdp_int_n}, 32'd0);
        sprite_collision = 1'b1;
        tick;
        sprite_collision = 1'b0;
        cpu_read(1'b1);
        check("status1", {24'b0, cpu_dout}, 32'hF5);
        check("int_n_cleared", {31'b0, vdp_int_n}, 32'd1);
        cpu_read(1'b1);
        check("status2", {24'b0, cpu_dout}, 32'h55);
        sprite_collision = 1'b1;
        cpu_read(1'b1);
        sprite_collision = 1'b0;
        check("status3_c_before_set", {24'b0, cpu_dout}, 32'h55);
        cpu_read(1'b1);
        check("status4_set_wins", {24'b0, cpu_dout}, 32'h75);
        cpu_read(1'b1);
        check("status5_cleared", {24'b0, cpu_dout}, 32'h55);

        // Status read resets the latch; write while busy is ignored.
        cpu_write(1'b1, 8'h34);
        cpu_read(1'b1);
        cpu_write(1'b1, 8'h12);
        cpu_write(1'b1, 8'h40);
        snap = wr_cnt;
        cpu_write(1'b0, 8'h77);
        check("latch_reset_addr", {18'b0, vga_addr}, 32'h0012);
        check("busy_during_wr", {31'b0, busy}, 32'd1);
        cpu_write(1'b0, 8'h99);
        check("busy_wr_no_pulse", {31'b0, vga_wr}, 32'd0);
        tick;
        tick;
        check("busy_wr_count", wr_cnt, snap + 1);
        check("busy_wr_last_addr", {18'b0, last_wr_addr}, 32'h0012);
        check("busy_wr_last_dat", {24'b0, last_wr_dat}, 32'h77);

        // Simultaneous write and read: write wins.
        port_sel = 1'b0;
        cpu_din  = 8'h3C;
        cpu_wr   = 1'b1;
        cpu_rd   = 1'b1;
        tick;
        cpu_wr   = 1'b0;
        cpu_rd   = 1'b0;
        check("conflict_wr", {31'b0, vga_wr}, 32'd1);
        check("conflict_rd", {31'b0, vga_rd}, 32'd0);
        check("conflict_addr", {18'b0, vga_addr}, 32'h0013);
        check("conflict_dout", {24'b0, cpu_dout}, 32'h55);
        wait_idle;

        // Reset in the middle of a prefetch aborts it.
        cpu_write(1'b1, 8'h00);
        cpu_write(1'b1, 8'h05);
        check("abort_pre_rd", {31'b0, vga_rd}, 32'd1);
        n_reset = 1'b0;
        #1;
        snap = rd_cnt;
        check("abort_rd", {31'b0, vga_rd}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_dout", {24'b0, cpu_dout}, 32'h00);
        check("abort_mode", {30'b0, mode}, 32'd1);
        #2;
        n_reset = 1'b1;
        repeat (3) tick;
        check("abort_no_pulse", rd_cnt, snap);
        check("abort_addr", {18'b0, vga_addr}, 32'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
